pixel_width_fifo: RTL and testbench
===================================

PIXEL_WIDTH_FIFO -- requirements
Module: pixel_width_fifo

Interface
REQ-001 SHALL have parameter WR_DATA_WIDTH, default 16: write-port word width in bits.
REQ-002 SHALL have parameter RD_DATA_WIDTH, default 8: read-port word width in bits; the larger width divided by the smaller (RATIO) SHALL be 1, 2, 4 or 8.
REQ-003 SHALL have parameter DEPTH_WIDTH, default 12: storage of 2**DEPTH_WIDTH words of W = max(WR_DATA_WIDTH, RD_DATA_WIDTH) bits.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 2044, in write words, and ALMOST_EMPTY_NUM, default 4, in read words.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_data  input  WR_DATA_WIDTH  write word; wr_en  input  1  write request.
REQ-008 wr_full  output  1; almost_full  output  1; wr_water_level  output  log2(WCAP)+1  write words held; wr_overflow  output  1  one-cycle pulse.
REQ-009 rd_en  input  1  read request; rd_data  output  RD_DATA_WIDTH  read word.
REQ-010 rd_empty  output  1; almost_empty  output  1; rd_water_level  output  log2(RCAP)+1  read words held; rd_underflow  output  1  one-cycle pulse.

Function
REQ-011 Capacities SHALL be WCAP = 2**DEPTH_WIDTH*W/WR_DATA_WIDTH and RCAP = 2**DEPTH_WIDTH*W/RD_DATA_WIDTH.
REQ-012 Narrow write: units SHALL pack into a W-bit word, first unit in least-significant bits; the word becomes readable only when its last unit is written.
REQ-013 Narrow read: each W-bit word SHALL unpack least-significant unit first; the word is freed after its last unit is read.
REQ-014 wr_water_level SHALL count write words in storage plus the pack register; rd_water_level SHALL count unread read words in complete stored words.
REQ-015 A write SHALL be accepted iff wr_en && !wr_full; a read SHALL be accepted iff rd_en && !rd_empty; a write and a read in the same cycle SHALL both be accepted.
REQ-016 wr_full = (wr_water_level == WCAP); rd_empty = (rd_water_level == 0); both SHALL be registered and SHALL reflect the accepted operations from the previous edge.
REQ-017 almost_full SHALL be (wr_water_level >= ALMOST_FULL_NUM); almost_empty SHALL be (rd_water_level <= ALMOST_EMPTY_NUM).
REQ-018 A word completed at edge N SHALL be counted in rd_water_level, and rd_empty SHALL deassert, in cycle N+1.
REQ-019 wr_en while wr_full SHALL pulse wr_overflow for one cycle and change no state; rd_en while rd_empty SHALL pulse rd_underflow for one cycle and change no state.
REQ-020 Read and write pointers SHALL wrap modulo 2**DEPTH_WIDTH; an extra wrap bit SHALL distinguish full from empty.
REQ-021 When RATIO = 1, the block SHALL behave as a plain single-clock FIFO with identical write and read counts.

Reset
REQ-022 While rst is high at a clk edge, pointers, pack/unpack state and level counters SHALL clear.
REQ-023 After reset: rd_empty = 1, wr_full = 0, almost_empty = 1, almost_full = 0, both water levels = 0, rd_data = 0, wr_overflow = 0, rd_underflow = 0.
REQ-024 rst asserted mid-operation SHALL discard all stored and partially packed data, and SHALL override a same-cycle wr_en or rd_en.

Configuration
REQ-025 With macro PIXEL_WIDTH_FIFO_FWFT_EN defined, rd_data SHALL present the head read word whenever rd_empty = 0, and an accepted rd_en SHALL advance it at the next edge.
REQ-026 With PIXEL_WIDTH_FIFO_FWFT_EN undefined, rd_data SHALL update one cycle after an accepted rd_en and SHALL hold its value otherwise.

Verification
REQ-027 Defaults, without FWFT: write 16'h1234 then 16'hABCD, then read 4 -> rd_data 8'h34, 8'h12, 8'hCD, 8'hAB, each 1 cycle after its rd_en.
REQ-028 Defaults: write 4096 words with no reads -> wr_full = 1 after the 4096th write edge; almost_full asserts at level 2044; rd_water_level = 8192; a 4097th wr_en pulses wr_overflow and the level stays 4096.
REQ-029 WR=8, RD=32: write 3 bytes -> rd_empty stays 1 and wr_water_level = 3; write a 4th byte 8'h44 after 8'h11, 8'h22, 8'h33 -> rd_empty = 0 the next cycle and the read returns 32'h44332211.
REQ-030 Empty FIFO: rd_en for one cycle -> rd_underflow = 1 for one cycle; rd_data and levels unchanged.
REQ-031 DEPTH_WIDTH=4, RATIO=1: simultaneous wr_en/rd_en for 100 cycles at level 8 -> the level stays 8, the data sequence is preserved across pointer wrap, and no flag toggles.
REQ-032 Half-full FIFO with a partial pack: assert rst for one cycle with wr_en=1 -> all outputs at reset values the next cycle, and a subsequent write/read returns only new data.

Source files
------------

// File: rtl/pixel_width_fifo.sv
// Single-clock FIFO with differing write/read widths (packs narrow writes, unpacks narrow reads).
// Define PIXEL_WIDTH_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module pixel_width_fifo #(
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int DEPTH_WIDTH      = 12,
  parameter int ALMOST_FULL_NUM  = 2044,
  parameter int ALMOST_EMPTY_NUM = 4,
  localparam int W        = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int WR_RATIO = W / WR_DATA_WIDTH,
  localparam int RD_RATIO = W / RD_DATA_WIDTH,
  localparam int WL_W     = DEPTH_WIDTH + $clog2(WR_RATIO) + 1,
  localparam int RL_W     = DEPTH_WIDTH + $clog2(RD_RATIO) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [WL_W-1:0]          wr_water_level,
  output logic                     wr_overflow,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [RL_W-1:0]          rd_water_level,
  output logic                     rd_underflow
);

  localparam int WR_LOG = $clog2(WR_RATIO);
  localparam int RD_LOG = $clog2(RD_RATIO);
  localparam int WSUB_W = (WR_RATIO > 1) ? WR_LOG : 1;
  localparam int RSUB_W = (RD_RATIO > 1) ? RD_LOG : 1;
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int WCAP   = DEPTH * WR_RATIO;
  localparam logic [WSUB_W-1:0] WSUB_LAST = WSUB_W'(WR_RATIO - 1);
  localparam logic [RSUB_W-1:0] RSUB_LAST = RSUB_W'(RD_RATIO - 1);

  logic [W-1:0]             r_mem [DEPTH];
  logic [W-1:0]             r_pack;
  logic [W-1:0]             w_pack_n;
  logic [W-1:0]             w_head_word;
  logic [RD_DATA_WIDTH-1:0] w_head;
  logic [DEPTH_WIDTH:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_n, w_rd_ptr_n, w_words_n;
  logic [WSUB_W-1:0]        r_wr_sub, w_wr_sub_n;
  logic [RSUB_W-1:0]        r_rd_sub, w_rd_sub_n;
  logic [WL_W-1:0]          r_wr_level, w_wr_level_n;
  logic [RL_W-1:0]          r_rd_level, w_rd_level_n;
  logic                     r_wr_full, r_rd_empty, r_wr_ovf, r_rd_unf;
  logic                     w_wr_acc, w_rd_acc, w_wr_last, w_rd_last;

  assign w_wr_acc  = wr_en & ~r_wr_full;
  assign w_rd_acc  = rd_en & ~r_rd_empty;
  assign w_wr_last = (r_wr_sub == WSUB_LAST);
  assign w_rd_last = (r_rd_sub == RSUB_LAST);

  assign w_head_word = r_mem[r_rd_ptr[DEPTH_WIDTH-1:0]];
  assign w_head      = w_head_word[r_rd_sub*RD_DATA_WIDTH +: RD_DATA_WIDTH];

  // Stage p0: next pointers, sub-unit counters and levels from this cycle's accepted ops
  always_comb begin
    w_pack_n = r_pack;
    w_pack_n[r_wr_sub*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
    w_wr_ptr_n = r_wr_ptr;
    w_wr_sub_n = r_wr_sub;
    w_rd_ptr_n = r_rd_ptr;
    w_rd_sub_n = r_rd_sub;
    if (w_wr_acc) begin
      if (w_wr_last) begin
        w_wr_ptr_n = r_wr_ptr + 1'b1;
        w_wr_sub_n = '0;
      end else begin
        w_wr_sub_n = r_wr_sub + 1'b1;
      end
    end
    if (w_rd_acc) begin
      if (w_rd_last) begin
        w_rd_ptr_n = r_rd_ptr + 1'b1;
        w_rd_sub_n = '0;
      end else begin
        w_rd_sub_n = r_rd_sub + 1'b1;
      end
    end
    // A partially read word still occupies its slot, so it counts fully on the write side
    w_words_n    = w_wr_ptr_n - w_rd_ptr_n;
    w_wr_level_n = (WL_W'(w_words_n) << WR_LOG) + WL_W'(w_wr_sub_n);
    w_rd_level_n = (RL_W'(w_words_n) << RD_LOG) - RL_W'(w_rd_sub_n);
  end

  // Stage p1: storage and pack register (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_pack <= w_pack_n;
    if (w_wr_acc && w_wr_last) r_mem[r_wr_ptr[DEPTH_WIDTH-1:0]] <= w_pack_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_sub   <= '0;
      r_rd_sub   <= '0;
      r_wr_level <= '0;
      r_rd_level <= '0;
      r_wr_full  <= 1'b0;
      r_rd_empty <= 1'b1;
      r_wr_ovf   <= 1'b0;
      r_rd_unf   <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_n;
      r_rd_ptr   <= w_rd_ptr_n;
      r_wr_sub   <= w_wr_sub_n;
      r_rd_sub   <= w_rd_sub_n;
      r_wr_level <= w_wr_level_n;
      r_rd_level <= w_rd_level_n;
      r_wr_full  <= (w_wr_level_n == WL_W'(WCAP));
      r_rd_empty <= (w_rd_level_n == '0);
      r_wr_ovf   <= wr_en & r_wr_full;
      r_rd_unf   <= rd_en & r_rd_empty;
    end
  end

`ifdef PIXEL_WIDTH_FIFO_FWFT_EN
  assign rd_data = r_rd_empty ? '0 : w_head;
`else
  logic [RD_DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else if (w_rd_acc) r_rd_data <= w_head;
  end

  assign rd_data = r_rd_data;
`endif

  assign wr_full        = r_wr_full;
  assign rd_empty       = r_rd_empty;
  assign wr_water_level = r_wr_level;
  assign rd_water_level = r_rd_level;
  assign almost_full    = (int'(r_wr_level) >= ALMOST_FULL_NUM);
  assign almost_empty   = (int'(r_rd_level) <= ALMOST_EMPTY_NUM);
  assign wr_overflow    = r_wr_ovf;
  assign rd_underflow   = r_rd_unf;

endmodule

// File: tb/tb_pixel_width_fifo.sv
// Directed bench for pixel_width_fifo: 16->8 default, 8->32 packing and 8->8 wrap instances.
module tb_pixel_width_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: defaults, 16-bit write, 8-bit read
  logic [15:0] wr_data0 = '0;
  logic        wr_en0 = 1'b0, rd_en0 = 1'b0;
  logic        full0, af0, ovf0, empty0, ae0, unf0;
  logic [12:0] wl0;
  logic [13:0] rl0;
  logic [7:0]  rd_data0;

  // u1: 8-bit write, 32-bit read, 16 words
  logic [7:0]  wr_data1 = '0;
  logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
  logic        full1, af1, ovf1, empty1, ae1, unf1;
  logic [6:0]  wl1;
  logic [4:0]  rl1;
  logic [31:0] rd_data1;

  // u2: 8-bit both sides, 16 words
  logic [7:0]  wr_data2 = '0;
  logic        wr_en2 = 1'b0, rd_en2 = 1'b0;
  logic        full2, af2, ovf2, empty2, ae2, unf2;
  logic [4:0]  wl2;
  logic [4:0]  rl2;
  logic [7:0]  rd_data2;

  pixel_width_fifo u0 (
    .clk(clk), .rst(rst), .wr_data(wr_data0), .wr_en(wr_en0), .wr_full(full0),
    .almost_full(af0), .wr_water_level(wl0), .wr_overflow(ovf0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_empty(empty0), .almost_empty(ae0), .rd_water_level(rl0),
    .rd_underflow(unf0));

  pixel_width_fifo #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(4),
                     .ALMOST_FULL_NUM(60), .ALMOST_EMPTY_NUM(2)) u1 (
    .clk(clk), .rst(rst), .wr_data(wr_data1), .wr_en(wr_en1), .wr_full(full1),
    .almost_full(af1), .wr_water_level(wl1), .wr_overflow(ovf1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_empty(empty1), .almost_empty(ae1), .rd_water_level(rl1),
    .rd_underflow(unf1));

  pixel_width_fifo #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4),
                     .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(4)) u2 (
    .clk(clk), .rst(rst), .wr_data(wr_data2), .wr_en(wr_en2), .wr_full(full2),
    .almost_full(af2), .wr_water_level(wl2), .wr_overflow(ovf2), .rd_en(rd_en2),
    .rd_data(rd_data2), .rd_empty(empty2), .almost_empty(ae2), .rd_water_level(rl2),
    .rd_underflow(unf2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty0); end
    checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full0); end
    checks++; if (ae0 !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", ae0); end
    checks++; if (af0 !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", af0); end
    checks++; if (wl0 !== 13'd0) begin errors++; $display("FAIL reset_wr_level got %0d exp 0", wl0); end
    checks++; if (rl0 !== 14'd0) begin errors++; $display("FAIL reset_rd_level got %0d exp 0", rl0); end
    checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data0); end
    checks++; if ({ovf0, unf0} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {ovf0, unf0}); end
    checks++; if ({empty1, empty2} !== 2'b11) begin errors++; $display("FAIL reset_empty_u1u2 got %b exp 11", {empty1, empty2}); end
  endtask

  task automatic test_byte_split();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'hCD; exp_b[3] = 8'hAB;
    wr_en0 = 1'b1; wr_data0 = 16'h1234; tick();
    wr_data0 = 16'hABCD; tick();
    wr_en0 = 1'b0;
    checks++; if (wl0 !== 13'd2) begin errors++; $display("FAIL split_wr_level got %0d exp 2", wl0); end
    checks++; if (rl0 !== 14'd4) begin errors++; $display("FAIL split_rd_level got %0d exp 4", rl0); end
    checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL split_empty got %b exp 0", empty0); end
    checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL split_hold_before_read got %h exp 00", rd_data0); end
    rd_en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rd_data0 !== exp_b[i]) begin errors++; $display("FAIL split_rd_data[%0d] got %h exp %h", i, rd_data0, exp_b[i]); end
    end
    rd_en0 = 1'b0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL split_drained_empty got %b exp 1", empty0); end
    checks++; if (wl0 !== 13'd0) begin errors++; $display("FAIL split_drained_wr_level got %0d exp 0", wl0); end
  endtask

  task automatic test_underflow();
    rd_en0 = 1'b1; tick(); rd_en0 = 1'b0;
    checks++; if (unf0 !== 1'b1) begin errors++; $display("FAIL underflow_pulse got %b exp 1", unf0); end
    checks++; if (rd_data0 !== 8'hAB) begin errors++; $display("FAIL underflow_rd_data got %h exp ab", rd_data0); end
    checks++; if ({wl0, rl0} !== 27'd0) begin errors++; $display("FAIL underflow_levels got %0d/%0d exp 0/0", wl0, rl0); end
    tick();
    checks++; if (unf0 !== 1'b0) begin errors++; $display("FAIL underflow_one_cycle got %b exp 0", unf0); end
  endtask

  task automatic test_fill_full();
    do_reset();
    wr_en0 = 1'b1;
    for (int k = 1; k <= 4096; k++) begin
      wr_data0 = 16'(k);
      tick();
      if (k == 2043) begin
        checks++; if (af0 !== 1'b0) begin errors++; $display("FAIL fill_af_2043 got %b exp 0", af0); end
      end
      if (k == 2044) begin
        checks++; if (af0 !== 1'b1) begin errors++; $display("FAIL fill_af_2044 got %b exp 1", af0); end
      end
      if (k == 4095) begin
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL fill_full_4095 got %b exp 0", full0); end
      end
    end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full0); end
    checks++; if (wl0 !== 13'd4096) begin errors++; $display("FAIL fill_wr_level got %0d exp 4096", wl0); end
    checks++; if (rl0 !== 14'd8192) begin errors++; $display("FAIL fill_rd_level got %0d exp 8192", rl0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", ovf0); end
    wr_data0 = 16'hFFFF; tick();
    wr_en0 = 1'b0;
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b exp 1", ovf0); end
    checks++; if (wl0 !== 13'd4096) begin errors++; $display("FAIL overflow_level got %0d exp 4096", wl0); end
    tick();
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got %b exp 0", ovf0); end
    rd_en0 = 1'b1; tick();
    checks++; if (rd_data0 !== 8'h01) begin errors++; $display("FAIL full_rd0 got %h exp 01", rd_data0); end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL full_half_read got %b exp 1", full0); end
    tick(); rd_en0 = 1'b0;
    checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL full_rd1 got %h exp 00", rd_data0); end
    checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL full_freed got %b exp 0", full0); end
    checks++; if (wl0 !== 13'd4095) begin errors++; $display("FAIL full_freed_level got %0d exp 4095", wl0); end
  endtask

  task automatic test_pack();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    do_reset();
    wr_en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data1 = bytes[i]; tick();
      checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL pack_empty[%0d] got %b exp 1", i, empty1); end
    end
    checks++; if (wl1 !== 7'd3) begin errors++; $display("FAIL pack_wr_level got %0d exp 3", wl1); end
    checks++; if (rl1 !== 5'd0) begin errors++; $display("FAIL pack_rd_level got %0d exp 0", rl1); end
    wr_data1 = bytes[3]; tick(); wr_en1 = 1'b0;
    checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL pack_complete_empty got %b exp 0", empty1); end
    checks++; if (rl1 !== 5'd1) begin errors++; $display("FAIL pack_complete_rd_level got %0d exp 1", rl1); end
    rd_en1 = 1'b1; tick(); rd_en1 = 1'b0;
    checks++; if (rd_data1 !== 32'h44332211) begin errors++; $display("FAIL pack_rd_data got %h exp 44332211", rd_data1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL pack_drained got %b exp 1", empty1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data2 = 8'(i); tick();
    end
    checks++; if (wl2 !== 5'd8) begin errors++; $display("FAIL b2b_fill_level got %0d exp 8", wl2); end
    rd_en2 = 1'b1;
    for (int c = 0; c < 100; c++) begin
      wr_data2 = 8'(c + 8); tick();
      checks++; if (rd_data2 !== 8'(c)) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", c, rd_data2, c); end
      checks++; if (wl2 !== 5'd8 || rl2 !== 5'd8) begin errors++; $display("FAIL b2b_level[%0d] got %0d/%0d exp 8/8", c, wl2, rl2); end
      checks++; if ({full2, empty2, af2, ae2, ovf2, unf2} !== 6'b0) begin errors++; $display("FAIL b2b_flags[%0d] got %b exp 000000", c, {full2, empty2, af2, ae2, ovf2, unf2}); end
    end
    wr_en2 = 1'b0; rd_en2 = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr_en1 = 1'b1;
    for (int j = 0; j < 34; j++) begin
      wr_data1 = 8'(j); tick();
    end
    wr_en1 = 1'b0;
    checks++; if (wl1 !== 7'd34) begin errors++; $display("FAIL midrst_pre_level got %0d exp 34", wl1); end
    rd_en1 = 1'b1; tick(); rd_en1 = 1'b0;
    checks++; if (rd_data1 !== 32'h03020100) begin errors++; $display("FAIL midrst_pre_read got %h exp 03020100", rd_data1); end
    rst = 1'b1; wr_en1 = 1'b1; wr_data1 = 8'hEE; tick();
    rst = 1'b0; wr_en1 = 1'b0;
    checks++; if ({empty1, full1, ae1, af1, ovf1, unf1} !== 6'b101000) begin errors++; $display("FAIL midrst_flags got %b exp 101000", {empty1, full1, ae1, af1, ovf1, unf1}); end
    checks++; if (wl1 !== 7'd0 || rl1 !== 5'd0) begin errors++; $display("FAIL midrst_levels got %0d/%0d exp 0/0", wl1, rl1); end
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL midrst_rd_data got %h exp 00000000", rd_data1); end
    wr_en1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wr_data1 = 8'hA1 + 8'(j); tick();
    end
    wr_en1 = 1'b0;
    checks++; if (rl1 !== 5'd1) begin errors++; $display("FAIL midrst_new_level got %0d exp 1", rl1); end
    rd_en1 = 1'b1; tick(); rd_en1 = 1'b0;
    checks++; if (rd_data1 !== 32'hA4A3A2A1) begin errors++; $display("FAIL midrst_new_data got %h exp a4a3a2a1", rd_data1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL midrst_new_empty got %b exp 1", empty1); end
  endtask

  initial begin
    test_reset();
    test_byte_split();
    test_underflow();
    test_fill_full();
    test_pack();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
